// File: rtl/rr_grant_arbiter4.sv
// rr_grant_arbiter4: 4-requester round-robin arbiter with registered one-hot
// and binary grant outputs. A grant is held until the owner pulses done or
// drops its request. The released owner is masked while the next owner is
// chosen, so the grant hands over with no idle cycle.
// Optional macro HOLD_TIMEOUT_EN: force a release after MAX_HOLD held cycles
// and pulse timeout_o for that one cycle.
module rr_grant_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Stop elaboration if the parameters are outside their legal range.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2**CNT_W) <= MAX_HOLD) begin : g_param_chk
    $error("rr_grant_arbiter4: illegal MAX_HOLD/CNT_W");
  end

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             to_q, to_d;

  logic [3:0]       arb_req;
  logic             found;
  logic [1:0]       sel;
  logic             rel_nat, expire, release_c;

  // Rotating priority search starting at ptr. In GRANT the owner's bit is
  // masked, so a releasing owner cannot win back its own grant.
  always_comb begin
    arb_req = req_i;
    if (state_q == GRANT) arb_req = req_i & ~gnt_q;
    found = 1'b0;
    sel   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && arb_req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        sel   = ptr_q + 2'(k);
      end
    end
  end

  // Release decision. When done and owner-drop arrive together they count as
  // one release. A done on the expiry cycle takes precedence, so no timeout.
  always_comb begin
    rel_nat = done_i | ~req_i[idx_q];
`ifdef HOLD_TIMEOUT_EN
    expire  = (cnt_q == CNT_W'(MAX_HOLD - 1)) && !rel_nat;
`else
    expire  = 1'b0;
`endif
    release_c = rel_nat | expire;
  end

  // Next-state and output registers: grant, hand over, or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << sel;
          idx_d   = sel;
          ptr_d   = sel + 2'd1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          to_d = expire;
          if (found) begin
            gnt_d = 4'b0001 << sel;
            idx_d = sel;
            ptr_d = sel + 2'd1;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset is asynchronous and clears every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = |gnt_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Bench for rr_grant_arbiter4: a table of per-cycle vectors followed by
// hand-written sequences for async reset and hold timeout. The bench pushes
// expected outputs to a queue when it drives each cycle and compares them
// after the clock edge.
module tb_rr_grant_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;
  logic       gnt_valid_o;
  logic       timeout_o;

  int checks   = 0;
  int failures = 0;

  rr_grant_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   step_no = 0;

  // Drive one cycle, queue the expected result, then compare after the edge.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                      input logic [1:0] ei, input logic ev, input logic et,
                      input string name);
    exp_t e;
    req_i  = r;
    done_i = d;
    sb.push_back('{eg, ei, ev, et});
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    checks++;
    if (gnt_o !== e.gnt || gnt_idx_o !== e.idx || gnt_valid_o !== e.valid ||
        timeout_o !== e.to) begin
      failures++;
      $display("FAIL %s step %0d: got gnt=%b idx=%0d valid=%b to=%b, want gnt=%b idx=%0d valid=%b to=%b",
               name, step_no, gnt_o, gnt_idx_o, gnt_valid_o, timeout_o,
               e.gnt, e.idx, e.valid, e.to);
    end
    checks++;
    if (!$onehot0(gnt_o) || (gnt_valid_o && gnt_o !== (4'b0001 << gnt_idx_o)) ||
        gnt_valid_o !== (|gnt_o)) begin
      failures++;
      $display("FAIL invariant step %0d: gnt=%b idx=%0d valid=%b", step_no,
               gnt_o, gnt_idx_o, gnt_valid_o);
    end
  endtask

  task automatic chk_reset(input string name);
    checks++;
    if (gnt_o !== 4'b0000 || gnt_idx_o !== 2'd0 || gnt_valid_o !== 1'b0 ||
        timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b to=%b, want all zero",
               name, gnt_o, gnt_idx_o, gnt_valid_o, timeout_o);
    end
  endtask

  vec_t tbl[29];

  initial begin
    // req done -> gnt idx valid timeout
    tbl[0]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // first grant to 0
    tbl[1]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0}; // zero-bubble handover
    tbl[3]  = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0}; // owner drop, idx held
    tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // ptr=3 wraps to 2
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0}; // ptr -> 0
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // rotation 0,1,2,3,0
    tbl[10] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[11] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[15] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[16] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[17] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[18] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[19] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[20] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[21] = '{4'b1110, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0}; // done+drop = one release
    tbl[22] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[23] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // no pre-emption
    tbl[24] = '{4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0}; // owner masked -> idle
    tbl[25] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // re-win after idle
    tbl[26] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[27] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0}; // done in IDLE ignored
    tbl[28] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};

    rst    = 1'b1;
    req_i  = 4'b0000;
    done_i = 1'b0;
    #1;
    chk_reset("reset_state");
    #11 rst = 1'b0;                 // t=12, between edges

    foreach (tbl[i])
      step(tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].idx, tbl[i].valid,
           tbl[i].to, "table");

    // Async reset while owner 3 holds: outputs clear before the next edge.
    #2 rst = 1'b1;
    #1 chk_reset("async_reset");
    req_i = 4'b0000;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    step(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "post_reset_ptr0");

`ifdef HOLD_TIMEOUT_EN
    step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, "to_idle");
    rst = 1'b1;
    #1 rst = 1'b0;
    step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "to_grant0");
    for (int i = 0; i < 3; i++)
      step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "to_hold0");
    step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "to_expire");
    for (int i = 0; i < 3; i++)
      step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "to_hold1");
    step(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "to_done_wins");
`else
    step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, "nt_idle");
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++)
      step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "no_timeout_hold");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
